avalon_st_pkt_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that merges NUM_IN Avalon-ST sink streams onto one Avalon-ST source stream.
- Sits upstream of the packet parser datapath so that several ingress ports share a single parser instance.
- A grant locks from the accepted sop beat to the accepted eop beat, so packets are never interleaved.
- Output is a single register stage that sustains full throughput (one beat per cycle).

---
 rtl/avalon_st_pkt_arbiter.sv | 166 ++++++++++++++++
 tb/tb_avalon_st_pkt_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_pkt_arbiter
// Brief    : Packet-granular round-robin merge of NUM_IN Avalon-ST sinks onto
//            one registered Avalon-ST source (grant held from sop to eop).
// Revision : 1.0 - initial release
// ============================================================================
module avalon_st_pkt_arbiter #(
    parameter  int WIDTH   = 512,
    parameter  int NUM_IN  = 4,
    localparam int EMPTY_W = $clog2(WIDTH/8),
    localparam int PORT_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN-1:0]           in_sop,
    input  logic [NUM_IN-1:0]           in_eop,
    input  logic [NUM_IN-1:0]           in_error,
    input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
    input  logic [NUM_IN*WIDTH-1:0]     in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_error,
    output logic [EMPTY_W-1:0]          out_empty,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [PORT_W-1:0]           cur_port,
    output logic                        locked,
    output logic                        proto_err
);

    localparam logic [PORT_W-1:0] c_last_init = PORT_W'(NUM_IN - 1);

    logic                r_locked;
    logic [PORT_W-1:0]   r_cur;
    logic [PORT_W-1:0]   r_last;
    logic                r_proto_err;
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic                r_out_error;
    logic [EMPTY_W-1:0]  r_out_empty;
    logic [WIDTH-1:0]    r_out_data;

    logic                w_can_accept;
    logic [NUM_IN-1:0]   w_eligible;
    logic [NUM_IN-1:0]   w_stray;
    logic [PORT_W-1:0]   w_sel;
    logic                w_sel_ok;
    logic                w_sel_valid;
    logic                w_sel_sop;
    logic                w_sel_eop;
    logic                w_sel_error;
    logic [EMPTY_W-1:0]  w_sel_empty;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_accept;
    logic                w_proto;

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_eligible   = in_valid & in_sop;
    assign w_stray      = in_valid & ~in_sop;

    // Lowest eligible port above r_last wins; otherwise wrap to the lowest eligible.
    always_comb begin
        w_sel    = r_cur;
        w_sel_ok = 1'b0;
        if (r_locked) begin
            w_sel    = r_cur;
            w_sel_ok = 1'b1;
        end else begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (w_eligible[i]) begin
                    w_sel    = PORT_W'(i);
                    w_sel_ok = 1'b1;
                end
            end
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (w_eligible[i] && (PORT_W'(i) > r_last)) begin
                    w_sel = PORT_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_error = 1'b0;
        w_sel_empty = '0;
        w_sel_data  = '0;
        in_ready    = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (PORT_W'(i) == w_sel) begin
                w_sel_valid = in_valid[i];
                w_sel_sop   = in_sop[i];
                w_sel_eop   = in_eop[i];
                w_sel_error = in_error[i];
                w_sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
                w_sel_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = w_sel_ok && w_can_accept;
            end
        end
    end

    assign w_accept = w_sel_ok && w_can_accept && w_sel_valid;

    // Unlocked: a mid-packet beat with nothing else moving. Locked: a fresh sop.
    assign w_proto = r_locked ? (w_accept && w_sel_sop)
                              : ((|w_stray) && !w_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked    <= 1'b0;
            r_cur       <= '0;
            r_last      <= c_last_init;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_proto;
            if (w_accept) begin
                r_cur <= w_sel;
                if (w_sel_eop) begin
                    r_locked <= 1'b0;
                    r_last   <= w_sel;
                end else if (w_sel_sop) begin
                    r_locked <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_error <= 1'b0;
            r_out_empty <= '0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= w_sel_sop;
            r_out_eop   <= w_sel_eop;
            r_out_error <= w_sel_error;
            r_out_empty <= w_sel_empty;
            r_out_data  <= w_sel_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign out_error = r_out_error;
    assign out_empty = r_out_empty;
    assign out_data  = r_out_data;
    assign cur_port  = r_cur;
    assign locked    = r_locked;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_st_pkt_arbiter
// Brief    : Scoreboard bench for avalon_st_pkt_arbiter (4 ports, 64-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_st_pkt_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int EW = 3;
    localparam int PW = 2;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic          err;
        logic [EW-1:0] empty;
        logic [W-1:0]  data;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_sop;
    logic [N-1:0]      in_eop;
    logic [N-1:0]      in_error;
    logic [N*EW-1:0]   in_empty;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              out_error;
    logic [EW-1:0]     out_empty;
    logic [W-1:0]      out_data;
    logic              out_ready;
    logic [PW-1:0]     cur_port;
    logic              locked;
    logic              proto_err;

    beat_t srcq [N][$];
    beat_t sbq  [$];
    int    n_vec = 0;
    int    n_err = 0;

    avalon_st_pkt_arbiter #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error),
        .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
        .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
        .cur_port(cur_port), .locked(locked), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source models: each port presents the head of its queue until accepted.
    initial begin
        logic [N-1:0] xfer;
        beat_t        b;
        in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0;
        in_empty = '0; in_data = '0;
        forever begin
            @(posedge clk);
            xfer = rst ? '0 : (in_valid & in_ready);
            #1;
            for (int p = 0; p < N; p++) begin
                if (xfer[p] && srcq[p].size() > 0) b = srcq[p].pop_front();
                b = (srcq[p].size() > 0) ? srcq[p][0] : '0;
                in_valid[p]           = (srcq[p].size() > 0);
                in_sop[p]             = b.sop;
                in_eop[p]             = b.eop;
                in_error[p]           = b.err;
                in_empty[p*EW +: EW]  = b.empty;
                in_data[p*W +: W]     = b.data;
            end
        end
    end

    // Monitor: every beat leaving the DUT must match the next expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL out_beat: unexpected beat data %0h at %0t", out_data, $time);
                end else begin
                    e = sbq.pop_front();
                    if (out_sop !== e.sop || out_eop !== e.eop || out_error !== e.err ||
                        out_data !== e.data || (e.eop && out_empty !== e.empty)) begin
                        n_err++;
                        $display("FAIL out_beat: got sop%b eop%b err%b empty%0d data %0h, expected sop%b eop%b err%b empty%0d data %0h",
                                 out_sop, out_eop, out_error, out_empty, out_data,
                                 e.sop, e.eop, e.err, e.empty, e.data);
                    end
                end
            end
        end
    end

    task automatic send(input int p, input logic sop, input logic eop, input logic err,
                        input logic [EW-1:0] empty, input logic [W-1:0] data, input bit exp_out);
        beat_t b;
        b = '{sop: sop, eop: eop, err: err, empty: empty, data: data};
        srcq[p].push_back(b);
        if (exp_out) sbq.push_back(b);
    endtask

    task automatic wait_acc(input int p);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_valid[p] && in_ready[p];
        end
        if (!ok) chk("wait_accept_timeout", 0, 1);
    endtask

    task automatic wait_out();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !out_valid && sbq.size() == 0 && srcq[0].size() == 0 && srcq[1].size() == 0 &&
                 srcq[2].size() == 0 && srcq[3].size() == 0;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < N; p++) srcq[p].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_locked",    W'(locked), 0);
        chk("rst_cur_port",  W'(cur_port), 0);
        chk("rst_proto_err", W'(proto_err), 0);
        chk("rst_out_data",  out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single 3-beat packet on port 2
        send(2, 1, 0, 0, 0, 64'hA, 1);
        send(2, 0, 0, 0, 0, 64'hB, 1);
        send(2, 0, 1, 0, 5, 64'hC, 1);
        wait_acc(2);
        @(negedge clk);
        chk("p2_latency_valid", W'(out_valid), 1);
        chk("p2_first_sop",     W'(out_sop), 1);
        chk("p2_locked_1",      W'(locked), 1);
        chk("p2_cur_port",      W'(cur_port), 2);
        @(negedge clk);
        chk("p2_locked_2",      W'(locked), 1);
        @(negedge clk);
        chk("p2_unlocked",      W'(locked), 0);
        chk("p2_eop_empty",     W'(out_empty), 5);
        chk("p2_cur_port_end",  W'(cur_port), 2);
        wait_idle();

        // Contention: all ports, 2-beat packets, order 0,1,2,3 after reset
        do_reset();
        for (int p = 0; p < N; p++) begin
            send(p, 1, 0, 0, 0, W'(64'h100 * p), 1);
            send(p, 0, 1, (p == 3), EW'(p), W'(64'h100 * p + 1), 1);
        end
        wait_out();
        for (int i = 0; i < 2 * N; i++) begin
            chk("contention_no_bubble", W'(out_valid), 1);
            @(negedge clk);
        end
        chk("contention_done", W'(out_valid), 0);
        wait_idle();

        // Backpressure on a 4-beat packet from port 1
        for (int b = 0; b < 4; b++) send(1, (b == 0), (b == 3), 0, 2, W'(64'h1B0 + b), 1);
        wait_out();
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_1", W'(in_ready[1]), 0);
        chk("bp_data_1",     out_data, 64'h1B1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_2", W'(in_ready[1]), 0);
        chk("bp_data_2",     out_data, 64'h1B1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Single-beat packets on ports 0 and 3 alternate
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(0, 1, 1, 0, 1, W'(64'h500 + k), 0);
            send(3, 1, 1, 0, 4, W'(64'h530 + k), 0);
        end
        for (int k = 0; k < 3; k++) begin
            sbq.push_back('{sop: 1, eop: 1, err: 0, empty: 1, data: W'(64'h500 + k)});
            sbq.push_back('{sop: 1, eop: 1, err: 0, empty: 4, data: W'(64'h530 + k)});
        end
        wait_out();
        for (int i = 0; i < 6; i++) begin
            chk("single_valid",  W'(out_valid), 1);
            chk("single_locked", W'(locked), 0);
            @(negedge clk);
        end
        wait_idle();

        // Stray mid-packet beat on port 1 while idle
        send(1, 0, 0, 0, 0, 64'hDEAD, 0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_proto_err", W'(proto_err), 1);
            chk("stray_in_ready",  W'(in_ready[1]), 0);
            chk("stray_no_output", W'(out_valid), 0);
        end
        srcq[1].delete();
        @(negedge clk);
        @(negedge clk);
        chk("stray_cleared", W'(proto_err), 0);

        // New sop while locked is forwarded and flagged
        send(0, 1, 0, 0, 0, 64'h51, 1);
        send(0, 1, 0, 0, 0, 64'h52, 1);
        send(0, 0, 1, 0, 0, 64'h53, 1);
        wait_acc(0);
        @(negedge clk);
        chk("relock_proto_0", W'(proto_err), 0);
        @(negedge clk);
        chk("relock_proto_1", W'(proto_err), 1);
        chk("relock_locked",  W'(locked), 1);
        @(negedge clk);
        chk("relock_proto_2", W'(proto_err), 0);
        chk("relock_unlock",  W'(locked), 0);
        wait_idle();

        // Asynchronous reset in the middle of a port 2 packet
        send(2, 1, 0, 0, 0, 64'h2A0, 1);
        send(2, 0, 0, 0, 0, 64'h2A1, 1);
        send(2, 0, 0, 0, 0, 64'h2A2, 0);
        send(2, 0, 1, 0, 3, 64'h2A3, 0);
        wait_acc(2);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid",  W'(out_valid), 0);
        chk("async_rst_locked", W'(locked), 0);
        chk("async_rst_data",   out_data, 0);
        for (int p = 0; p < N; p++) srcq[p].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 4; b++) send(2, (b == 0), (b == 3), 0, 3, W'(64'h2B0 + b), 0);
        send(0, 1, 0, 0, 0, 64'h0B0, 1);
        send(0, 0, 1, 0, 6, 64'h0B1, 1);
        for (int b = 0; b < 4; b++)
            sbq.push_back('{sop: (b == 0), eop: (b == 3), err: 0, empty: 3, data: W'(64'h2B0 + b)});
        wait_out();
        chk("post_rst_cur_port", W'(cur_port), 0);
        chk("post_rst_locked",   W'(locked), 1);
        wait_idle();

        chk("scoreboard_drained", W'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
